// File: rtl/medida_serial_tx_n.sv
// medida_serial_tx_n
// Serial frame transmitter for BCD distance measurements. A single
// `partida` pulse latches N_DIGITS packed BCD digits. Each digit is sent
// as ASCII (with optional leading-zero blanking), followed by a terminator,
// over a 7-data-bit UART with one parity bit and one stop bit.
//
// Timing: the line register is loaded from the bit value of the current
// state. It therefore trails the FSM by exactly one cycle. This is why the
// start bit of the first character appears two edges after the accepting
// edge, and why every inter-character gap is two cycles long.
module medida_serial_tx_n #(
    parameter int         N_DIGITS     = 3,
    parameter int         CLKS_PER_BIT = 5208,
    parameter logic [6:0] TERMINATOR   = 7'h23,
    parameter bit         PARITY_ODD   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  partida,
    input  logic [4*N_DIGITS-1:0] digitos,
    input  logic                  suprime_zeros,
    output logic                  saida_serial,
    output logic                  ocupado,
    output logic                  pronto,
    output logic                  erro_bcd,
    output logic [3:0]            db_estado
);

    localparam int IW = (N_DIGITS < 2) ? 1 : $clog2(N_DIGITS + 1);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] ULT_CLK = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'h0,
        CARREGA  = 4'h1,
        START    = 4'h2,
        DADOS    = 4'h3,
        PARIDADE = 4'h4,
        STOP     = 4'h5,
        PROXIMO  = 4'h6,
        FIM      = 4'h7
    } estado_t;

    estado_t               estado;
    logic [4*N_DIGITS-1:0] dig_lat;
    logic                  sup_lat;
    logic [IW-1:0]         indice;
    logic [CW-1:0]         cnt_clk;
    logic [2:0]            cnt_bit;
    logic [6:0]            shreg;
    logic                  par_bit;

    logic [6:0]            car_sel;
    logic                  car_err;
    logic                  lead;
    logic [3:0]            dig_cur;
    logic                  linha;

    assign db_estado = estado;

    // Build the character for the current index from the latched digits.
    // A digit is blanked only while every digit up to and including it is
    // zero. The least significant digit is never blanked. An invalid digit
    // counts as nonzero.
    always_comb begin
        car_sel = TERMINATOR;
        car_err = 1'b0;
        lead    = 1'b1;
        dig_cur = 4'h0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j <= int'(indice) && dig_lat[4*(N_DIGITS-1-j) +: 4] != 4'h0)
                lead = 1'b0;
            if (j == int'(indice))
                dig_cur = dig_lat[4*(N_DIGITS-1-j) +: 4];
        end
        if (int'(indice) < N_DIGITS) begin
            if (dig_cur > 4'd9) begin
                car_sel = 7'h3F;
                car_err = 1'b1;
            end else if (sup_lat && lead && int'(indice) != N_DIGITS - 1) begin
                car_sel = 7'h20;
            end else begin
                car_sel = {3'b011, dig_cur};
            end
        end
    end

    // Select the line level that corresponds to the current FSM state.
    always_comb begin
        linha = 1'b1;
        case (estado)
            START:    linha = 1'b0;
            DADOS:    linha = shreg[0];
            PARIDADE: linha = par_bit;
            default:  linha = 1'b1;
        endcase
    end

    // Frame sequencer. It handles character load, bit timing, the
    // character index and the status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= IDLE;
            dig_lat      <= '0;
            sup_lat      <= 1'b0;
            indice       <= '0;
            cnt_clk      <= '0;
            cnt_bit      <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            saida_serial <= 1'b1;
            ocupado      <= 1'b0;
            pronto       <= 1'b0;
            erro_bcd     <= 1'b0;
        end else begin
            saida_serial <= linha;
            case (estado)
                IDLE: begin
                    pronto <= 1'b0;
                    if (partida) begin
                        dig_lat  <= digitos;
                        sup_lat  <= suprime_zeros;
                        erro_bcd <= 1'b0;
                        indice   <= '0;
                        ocupado  <= 1'b1;
                        estado   <= CARREGA;
                    end
                end
                CARREGA: begin
                    shreg   <= car_sel;
                    par_bit <= PARITY_ODD ? ~(^car_sel) : ^car_sel;
                    if (car_err)
                        erro_bcd <= 1'b1;
                    cnt_clk <= '0;
                    cnt_bit <= '0;
                    estado  <= START;
                end
                START: begin
                    if (cnt_clk == ULT_CLK) begin
                        cnt_clk <= '0;
                        estado  <= DADOS;
                    end else begin
                        cnt_clk <= cnt_clk + 1'b1;
                    end
                end
                DADOS: begin
                    if (cnt_clk == ULT_CLK) begin
                        cnt_clk <= '0;
                        shreg   <= {1'b0, shreg[6:1]};
                        if (cnt_bit == 3'd6)
                            estado <= PARIDADE;
                        else
                            cnt_bit <= cnt_bit + 1'b1;
                    end else begin
                        cnt_clk <= cnt_clk + 1'b1;
                    end
                end
                PARIDADE: begin
                    if (cnt_clk == ULT_CLK) begin
                        cnt_clk <= '0;
                        estado  <= STOP;
                    end else begin
                        cnt_clk <= cnt_clk + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_clk == ULT_CLK) begin
                        cnt_clk <= '0;
                        estado  <= PROXIMO;
                    end else begin
                        cnt_clk <= cnt_clk + 1'b1;
                    end
                end
                PROXIMO: begin
                    if (int'(indice) < N_DIGITS) begin
                        indice <= indice + 1'b1;
                        estado <= CARREGA;
                    end else begin
                        ocupado <= 1'b0;
                        pronto  <= 1'b1;
                        estado  <= FIM;
                    end
                end
                FIM: begin
                    pronto <= 1'b0;
                    estado <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_medida_serial_tx_n.sv
// Testbench for medida_serial_tx_n. It drives three instances:
// u0 uses N=3, 4 clocks/bit, odd parity; u1 is the same with even parity;
// u2 uses N=5, 2 clocks/bit, odd parity. A UART receiver built into the
// bench decodes every byte. The bytes are compared with a frame model
// computed from the digit values.
module tb_medida_serial_tx_n;

    logic        clk = 1'b0;
    logic        rst  [3];
    logic        part [3];
    logic        sup  [3];
    logic [31:0] dig  [3];
    logic        ser  [3];
    logic        ocu  [3];
    logic        pro  [3];
    logic        err  [3];
    logic [3:0]  est  [3];

    int NN [3] = '{3, 3, 5};
    int CP [3] = '{4, 4, 2};
    bit OD [3] = '{1'b1, 1'b0, 1'b1};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int npro [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++)
            if (pro[i] === 1'b1) npro[i] <= npro[i] + 1;
    end

    medida_serial_tx_n #(.N_DIGITS(3), .CLKS_PER_BIT(4), .TERMINATOR(7'h23), .PARITY_ODD(1'b1)) u0 (
        .clock(clk), .reset(rst[0]), .partida(part[0]), .digitos(dig[0][11:0]),
        .suprime_zeros(sup[0]), .saida_serial(ser[0]), .ocupado(ocu[0]),
        .pronto(pro[0]), .erro_bcd(err[0]), .db_estado(est[0]));

    medida_serial_tx_n #(.N_DIGITS(3), .CLKS_PER_BIT(4), .TERMINATOR(7'h23), .PARITY_ODD(1'b0)) u1 (
        .clock(clk), .reset(rst[1]), .partida(part[1]), .digitos(dig[1][11:0]),
        .suprime_zeros(sup[1]), .saida_serial(ser[1]), .ocupado(ocu[1]),
        .pronto(pro[1]), .erro_bcd(err[1]), .db_estado(est[1]));

    medida_serial_tx_n #(.N_DIGITS(5), .CLKS_PER_BIT(2), .TERMINATOR(7'h23), .PARITY_ODD(1'b1)) u2 (
        .clock(clk), .reset(rst[2]), .partida(part[2]), .digitos(dig[2][19:0]),
        .suprime_zeros(sup[2]), .saida_serial(ser[2]), .ocupado(ocu[2]),
        .pronto(pro[2]), .erro_bcd(err[2]), .db_estado(est[2]));

    // Pulse partida for one edge. t0 is the cycle count just after the
    // accepting edge. The digit input is then scrambled to show that the
    // latched copy is the one transmitted.
    task automatic start_frame(input int u, input logic [31:0] d, input bit s, output int t0);
        @(negedge clk);
        dig[u]  = d;
        sup[u]  = s;
        part[u] = 1'b1;
        @(negedge clk);
        part[u] = 1'b0;
        dig[u]  = $urandom;
        sup[u]  = ~s;
        t0 = cyc;
    endtask

    // Receive one frame and check its bytes, parity, stop bits and bit
    // timing, then the pronto timing and the error flag. If ign is set,
    // partida is held high while the frame is in flight. If chain is set,
    // partida is raised in FIM and held through IDLE, which starts a new
    // frame with d2/s2; its t0 is returned in t0n.
    task automatic rx_check(input int u, input logic [31:0] d, input bit s, input int t0,
                            input bit ign, input bit chain, input logic [31:0] d2,
                            input bit s2, input string tag, output int t0n);
        int n, cpb, w, base, per;
        bit seen, exp_e, ep;
        int v;
        logic [7:0] ec [9];
        logic [6:0] got;
        logic gp, gs;
        t0n = 0;
        n = NN[u]; cpb = CP[u]; base = npro[u]; per = 10 * cpb + 2;
        seen = 1'b0; exp_e = 1'b0;
        for (int i = 0; i < n; i++) begin
            v = int'((d >> (4 * (n - 1 - i))) & 32'hF);
            if (v != 0) seen = 1'b1;
            if (v > 9) begin ec[i] = 8'h3F; exp_e = 1'b1; end
            else if (s && !seen && i != n - 1) ec[i] = 8'h20;
            else ec[i] = 8'h30 + 8'(v);
        end
        ec[n] = 8'h23;
        total++;
        if (err[u] !== 1'b0) begin
            bad++; $display("FAIL %s err_clear_on_start got=%b want=0", tag, err[u]);
        end
        if (ign) part[u] = 1'b1;
        for (int i = 0; i <= n; i++) begin
            w = 0;
            while (ser[u] !== 1'b0 && w < 20 * cpb + 20) begin @(negedge clk); w++; end
            total++;
            if (ser[u] !== 1'b0) begin
                bad++; $display("FAIL %s start_timeout char=%0d", tag, i);
                part[u] = 1'b0;
                return;
            end
            total++;
            if (cyc !== t0 + 2 + i * per) begin
                bad++; $display("FAIL %s start_time char=%0d got=%0d want=%0d", tag, i, cyc - t0, 2 + i * per);
            end
            total++;
            if (ocu[u] !== 1'b1) begin
                bad++; $display("FAIL %s busy char=%0d got=%b want=1", tag, i, ocu[u]);
            end
            repeat (cpb / 2) @(negedge clk);
            for (int b = 0; b < 7; b++) begin
                repeat (cpb) @(negedge clk);
                got[b] = ser[u];
            end
            repeat (cpb) @(negedge clk);
            gp = ser[u];
            repeat (cpb) @(negedge clk);
            gs = ser[u];
            if (i == n) part[u] = 1'b0;
            ep = OD[u] ? ($countones(ec[i][6:0]) % 2 == 0) : ($countones(ec[i][6:0]) % 2 == 1);
            total++;
            if (got !== ec[i][6:0]) begin
                bad++; $display("FAIL %s byte char=%0d got=%h want=%h", tag, i, got, ec[i][6:0]);
            end
            total++;
            if (gp !== ep) begin
                bad++; $display("FAIL %s parity char=%0d got=%b want=%b", tag, i, gp, ep);
            end
            total++;
            if (gs !== 1'b1) begin
                bad++; $display("FAIL %s stop char=%0d got=%b want=1", tag, i, gs);
            end
        end
        w = 0;
        while (pro[u] !== 1'b1 && w < 20 * cpb + 20) begin @(negedge clk); w++; end
        total++;
        if (cyc !== t0 + (n + 1) * per) begin
            bad++; $display("FAIL %s done_time got=%0d want=%0d", tag, cyc - t0, (n + 1) * per);
        end
        total++;
        if (ocu[u] !== 1'b0) begin
            bad++; $display("FAIL %s busy_at_done got=%b want=0", tag, ocu[u]);
        end
        total++;
        if (err[u] !== exp_e) begin
            bad++; $display("FAIL %s err got=%b want=%b", tag, err[u], exp_e);
        end
        if (chain) begin
            part[u] = 1'b1; dig[u] = d2; sup[u] = s2;
        end
        @(negedge clk);
        total++;
        if (pro[u] !== 1'b0 || est[u] !== 4'h0) begin
            bad++; $display("FAIL %s after_done pronto=%b state=%h want 0/0", tag, pro[u], est[u]);
        end
        total++;
        if (npro[u] - base !== 1) begin
            bad++; $display("FAIL %s done_pulses got=%0d want=1", tag, npro[u] - base);
        end
        if (chain) begin
            @(negedge clk);
            part[u] = 1'b0;
            dig[u]  = $urandom;
            t0n = cyc;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; part[i] = 1'b0; sup[i] = 1'b0; dig[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ser[i] !== 1'b1 || ocu[i] !== 1'b0 || pro[i] !== 1'b0 || err[i] !== 1'b0 || est[i] !== 4'h0) begin
                bad++;
                $display("FAIL reset u%0d got ser=%b ocu=%b pro=%b err=%b st=%h want 1/0/0/0/0",
                         i, ser[i], ocu[i], pro[i], err[i], est[i]);
            end
            rst[i] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int t0, tn;
        start_frame(0, 32'h123, 1'b0, t0);
        rx_check(0, 32'h123, 1'b0, t0, 1'b0, 1'b0, 0, 1'b0, "basic_123", tn);
    endtask

    task automatic test_suppress();
        int t0, tn;
        logic [31:0] v [3] = '{32'h007, 32'h000, 32'h305};
        for (int i = 0; i < 3; i++) begin
            start_frame(0, v[i], 1'b1, t0);
            rx_check(0, v[i], 1'b1, t0, 1'b0, 1'b0, 0, 1'b0, "suppress", tn);
        end
    endtask

    task automatic test_bad_digit();
        int t0, tn;
        start_frame(0, 32'h0A5, 1'b1, t0);
        rx_check(0, 32'h0A5, 1'b1, t0, 1'b0, 1'b0, 0, 1'b0, "bad_0A5", tn);
        repeat (15) @(negedge clk);
        total++;
        if (err[0] !== 1'b1) begin
            bad++; $display("FAIL err_sticky got=%b want=1", err[0]);
        end
        start_frame(0, 32'h456, 1'b0, t0);
        rx_check(0, 32'h456, 1'b0, t0, 1'b0, 1'b0, 0, 1'b0, "err_cleared", tn);
    endtask

    task automatic test_even_parity();
        int t0, tn;
        start_frame(1, 32'h131, 1'b0, t0);
        rx_check(1, 32'h131, 1'b0, t0, 1'b0, 1'b0, 0, 1'b0, "even_131", tn);
    endtask

    task automatic test_ignore();
        int t0, tn;
        bit extra;
        start_frame(0, 32'h789, 1'b0, t0);
        rx_check(0, 32'h789, 1'b0, t0, 1'b1, 1'b0, 0, 1'b0, "ignore_start", tn);
        extra = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ocu[0] !== 1'b0 || ser[0] !== 1'b1) extra = 1'b1;
        end
        total++;
        if (extra) begin
            bad++; $display("FAIL ignore_extra_frame got=1 want=0");
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1, tn;
        start_frame(0, 32'h246, 1'b0, t0);
        rx_check(0, 32'h246, 1'b0, t0, 1'b0, 1'b1, 32'h090, 1'b1, "b2b_first", t1);
        rx_check(0, 32'h090, 1'b1, t1, 1'b0, 1'b0, 0, 1'b0, "b2b_second", tn);
    endtask

    task automatic test_reset_mid();
        int t0, tn, w;
        start_frame(0, 32'h123, 1'b0, t0);
        w = 0;
        while (cyc < t0 + 2 + 42 + 4 + 1 && w < 200) begin @(negedge clk); w++; end
        total++;
        if (ser[0] !== 1'b0) begin
            bad++; $display("FAIL mid_data_bit got=%b want=0", ser[0]);
        end
        rst[0] = 1'b1;
        @(negedge clk);
        total++;
        if (ser[0] !== 1'b1 || ocu[0] !== 1'b0 || est[0] !== 4'h0 || pro[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got ser=%b ocu=%b st=%h pro=%b want 1/0/0/0", ser[0], ocu[0], est[0], pro[0]);
        end
        rst[0] = 1'b0;
        repeat (2) @(negedge clk);
        start_frame(0, 32'h123, 1'b0, t0);
        rx_check(0, 32'h123, 1'b0, t0, 1'b0, 1'b0, 0, 1'b0, "after_reset", tn);
    endtask

    task automatic test_n5();
        int t0, tn;
        start_frame(2, 32'h09876, 1'b1, t0);
        rx_check(2, 32'h09876, 1'b1, t0, 1'b0, 1'b0, 0, 1'b0, "n5_09876", tn);
    endtask

    task automatic test_random();
        int t0, tn, u;
        logic [31:0] d;
        bit s;
        for (int k = 0; k < 12; k++) begin
            u = (k < 6) ? 0 : (k < 9) ? 1 : 2;
            d = '0;
            for (int j = 0; j < NN[u]; j++)
                d = (d << 4) | (($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(0, 11)));
            s = 1'($urandom_range(0, 1));
            start_frame(u, d, s, t0);
            rx_check(u, d, s, t0, 1'b0, 1'b0, 0, 1'b0, "random", tn);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_suppress();
        test_bad_digit();
        test_even_parity();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_n5();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
